// File: rtl/sig_src_fade_mux.sv
// sig_src_fade_mux: N-source sample selector with a
// linear gain ramp (fade-out, then fade-in) on source change.
module sig_src_fade_mux #(
  parameter int WIDTH      = 16,
  parameter int N_SRC      = 8,
  parameter int FADE_SHIFT = 4,
  localparam int SEL_W     = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [N_SRC*WIDTH-1:0] d_i,
  input  logic                   valid_i,
  output logic [WIDTH-1:0]       y_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic [SEL_W-1:0]       cur_sel_o
);

  localparam int GW = FADE_SHIFT + 1;
  localparam int PW = WIDTH + FADE_SHIFT + 1;
  localparam logic [GW-1:0] FULL = GW'(1) << FADE_SHIFT;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2,
    MUTE     = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [GW-1:0]     g, g_n;
  logic [SEL_W-1:0]  cur_sel, cur_n;
  logic              in_rng, mis;
  logic [WIDTH-1:0]  samp;
  logic signed [PW-1:0] samp_x, g_x, prod;
  logic [WIDTH-1:0]  y_n;

  assign in_rng = int'(sel_i) < N_SRC;
  assign mis    = (sel_i != cur_sel) || !in_rng;

  always_comb begin
    samp = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (cur_sel == SEL_W'(k))
        samp = d_i[k*WIDTH +: WIDTH];
    end
  end

  // g never exceeds FULL, so the shifted product fits WIDTH
  assign samp_x = PW'($signed(samp));
  assign g_x    = PW'({1'b0, g});
  assign prod   = samp_x * g_x;
  assign y_n    = WIDTH'(prod >>> FADE_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FADE_IN;
      g       <= '0;
      cur_sel <= '0;
      y_o     <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_n;
      g       <= g_n;
      cur_sel <= cur_n;
      valid_o <= valid_i;
      if (valid_i)
        y_o <= y_n;
    end
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    cur_n   = cur_sel;
    if (valid_i) begin
      case (state)
        RUN: begin
          if (mis)
            state_n = FADE_OUT;
        end
        FADE_OUT: begin
          if (sel_i == cur_sel) begin
            state_n = FADE_IN;
          end else if (g == '0) begin
            if (in_rng) begin
              cur_n   = sel_i;
              state_n = FADE_IN;
            end else begin
              state_n = MUTE;
            end
          end else begin
            g_n = g - GW'(1);
          end
        end
        FADE_IN: begin
          if (mis)
            state_n = FADE_OUT;
          else if (g == FULL)
            state_n = RUN;
          else
            g_n = g + GW'(1);
        end
        MUTE: begin
          if (in_rng) begin
            cur_n   = sel_i;
            state_n = FADE_IN;
          end
        end
        default: state_n = FADE_IN;
      endcase
    end
  end

  always_comb begin
    busy_o    = (state != RUN);
    cur_sel_o = cur_sel;
  end

endmodule
